if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/musa_pkg.sv | 21 ++
 rtl/if_skid_buffer.sv | 39 +++
 rtl/if_stage.sv | 117 +++++++++++
 3 files changed

// File: rtl/musa_pkg.sv
`default_nettype none
// ============================================================================
// Module   : musa_pkg
// Purpose  : Shared widths, default constants and fetch-stage state encoding.
// Revision : 1.0
// ============================================================================
package musa_pkg;

  localparam int unsigned c_WORD_W = 32;

  localparam logic [c_WORD_W-1:0] c_NOP_INSTR  = 32'h0000_0000;
  localparam logic [c_WORD_W-1:0] c_RESET_ADDR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } if_state_t;

endpackage : musa_pkg
`default_nettype wire

// File: rtl/if_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module   : if_skid_buffer
// Purpose  : One-entry holding slot for a fetched word that arrived under stall.
// Revision : 1.0
// ============================================================================
module if_skid_buffer
  import musa_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                load,
  input  logic                unload,
  input  logic                flush,
  input  logic [c_WORD_W-1:0] load_data,
  input  logic [c_WORD_W-1:0] load_pc,
  output logic [c_WORD_W-1:0] data,
  output logic [c_WORD_W-1:0] pc,
  output logic                full
);

  always_ff @(posedge clock) begin
    if (reset) begin
      full <= 1'b0;
      data <= '0;
      pc   <= '0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      data <= load_data;
      pc   <= load_pc;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

endmodule : if_skid_buffer
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Purpose  : Instruction fetch with redirect, stall hold buffer and drain of
//            in-flight requests abandoned by a redirect.
// Revision : 1.0
// ============================================================================
module if_stage
  import musa_pkg::*;
#(
  parameter logic [c_WORD_W-1:0] RESET_ADDR = c_RESET_ADDR,
  parameter logic [c_WORD_W-1:0] NOP_INSTR  = c_NOP_INSTR
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [c_WORD_W-1:0] next_address,
  input  logic                take_branch,
  input  logic                stall,
  output logic [c_WORD_W-1:0] imem_addr,
  output logic                imem_req,
  input  logic                imem_ack,
  input  logic [c_WORD_W-1:0] imem_data,
  output logic [c_WORD_W-1:0] instruction,
  output logic [c_WORD_W-1:0] pc_out,
  output logic                valid
);

  localparam logic [c_WORD_W-1:0] c_PC_STEP    = 32'd4;
  localparam logic [c_WORD_W-1:0] c_ALIGN_MASK = 32'hFFFF_FFFC;

  if_state_t           r_state;
  logic [c_WORD_W-1:0] r_pc;
  logic [c_WORD_W-1:0] r_drain_addr;

  logic [c_WORD_W-1:0] w_target;
  logic                w_buf_load;
  logic                w_buf_unload;
  logic [c_WORD_W-1:0] w_buf_data;
  logic [c_WORD_W-1:0] w_buf_pc;
  logic                w_buf_full;

  assign w_target     = next_address & c_ALIGN_MASK;
  assign w_buf_load   = (r_state == FETCH) && imem_ack && stall && !take_branch;
  assign w_buf_unload = (r_state == HOLD) && !stall && !take_branch;

  // While draining, the bus keeps the abandoned address until its ack arrives.
  assign imem_req  = (r_state != HOLD);
  assign imem_addr = (r_state == DRAIN) ? r_drain_addr : r_pc;

  if_skid_buffer u_skid (
    .clock     (clock),
    .reset     (reset),
    .load      (w_buf_load),
    .unload    (w_buf_unload),
    .flush     (take_branch),
    .load_data (imem_data),
    .load_pc   (r_pc),
    .data      (w_buf_data),
    .pc        (w_buf_pc),
    .full      (w_buf_full)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= FETCH;
      r_pc         <= RESET_ADDR;
      r_drain_addr <= '0;
      instruction  <= NOP_INSTR;
      pc_out       <= '0;
      valid        <= 1'b0;
    end else if (take_branch) begin
      r_pc        <= w_target;
      instruction <= NOP_INSTR;
      valid       <= 1'b0;
      case (r_state)
        FETCH: begin
          if (!imem_ack) begin
            r_state      <= DRAIN;
            r_drain_addr <= r_pc;
          end
        end
        HOLD:    r_state <= FETCH;
        DRAIN:   if (imem_ack) r_state <= FETCH;
        default: r_state <= FETCH;
      endcase
    end else begin
      case (r_state)
        FETCH: begin
          if (imem_ack) begin
            r_pc <= r_pc + c_PC_STEP;
            if (stall) begin
              r_state <= HOLD;
            end else begin
              instruction <= imem_data;
              pc_out      <= r_pc;
              valid       <= 1'b1;
            end
          end else if (!stall) begin
            valid <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            instruction <= w_buf_data;
            pc_out      <= w_buf_pc;
            valid       <= w_buf_full;
            r_state     <= FETCH;
          end
        end
        DRAIN:   if (imem_ack) r_state <= FETCH;
        default: r_state <= FETCH;
      endcase
    end
  end

endmodule : if_stage
`default_nettype wire
